mem_port_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory among three requesters: instruction

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between instruction
// fetch (IF), data access (DM) and the interrupt vector read (IV).
// Grants are combinational; read data returns one cycle after the grant and is
// steered to the owner recorded in owner_q.
// Optional feature: define ARB_STARVE_GUARD_EN to add the IF starvation guard,
// which forces one IF grant after STARVE_MAX back-to-back dm/iv grants.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = 8'h01
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_lock,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic              dm_stall,
  input  logic              iv_req,
  output logic              iv_gnt,
  output logic              iv_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_IV} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_priority;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  // IF jumps the queue once enough dm/iv grants have passed it by (IDLE only).
  always_comb begin
    if_priority = (starve_q >= 3'(STARVE_MAX));
  end

  // Count dm/iv grants that bypass a waiting fetch; saturate, clear on if grant.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if ((dm_gnt || iv_gnt) && if_req && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Fixed priority only: fetch never jumps the queue.
  always_comb begin
    if_priority = 1'b0;
  end
`endif

  // Grant selection: LOCK serves only dm; IDLE uses iv > dm > if (guard may lift if).
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    iv_gnt = 1'b0;
    if (rst) begin
      if (state_q == ST_LOCK) begin
        dm_gnt = dm_req;
      end else if (if_priority && if_req) begin
        if_gnt = 1'b1;
      end else if (iv_req) begin
        iv_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Drive the memory macro for the granted requester and note who owns the read.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    owner_d   = OWN_NONE;
    if (if_gnt) begin
      mem_addr = if_addr;
      mem_re   = 1'b1;
      owner_d  = OWN_IF;
    end else if (dm_gnt) begin
      mem_addr = dm_addr;
      if (dm_we) begin
        mem_we    = 1'b1;
        mem_wdata = dm_wdata;
      end else begin
        mem_re  = 1'b1;
        owner_d = OWN_DM;
      end
    end else if (iv_gnt) begin
      mem_addr = INT_VEC_ADDR;
      mem_re   = 1'b1;
      owner_d  = OWN_IV;
    end
  end

  // Lock FSM: a locked dm grant keeps the port until dm releases the lock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dm_gnt && dm_lock) state_d = ST_LOCK;
      ST_LOCK: if ((dm_gnt && !dm_lock) || (!dm_req && !dm_lock)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data passes through in the rvalid cycle and is held afterwards.
  always_comb begin
    rdata_d = (owner_q != OWN_NONE) ? mem_rdata : rdata_q;
  end

  assign rdata     = rdata_d;
  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);
  assign iv_rvalid = (owner_q == OWN_IV);
  assign if_stall  = rst & if_req & ~if_gnt;
  assign dm_stall  = rst & dm_req & ~dm_gnt;

  // State, read-owner and held read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural arbitration model with a read-return scoreboard.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int SMAX   = 4;
  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_DM   = 2;
  localparam int G_IV   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_lock = 1'b0, iv_req = 1'b0;
  logic [7:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic       if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall, iv_gnt, iv_rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_lock(dm_lock), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_stall(dm_stall),
    .iv_req(iv_req), .iv_gnt(iv_gnt), .iv_rvalid(iv_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Synchronous memory macro: one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Reference model state.
  logic [7:0] ref_mem [256];
  bit         m_locked = 1'b0;
  int         m_starve = 0;

  typedef struct {int who; logic [7:0] data; int stamp;} exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2:0] ownerBits(input int who);
    case (who)
      G_IF:    return 3'b001;
      G_DM:    return 3'b010;
      G_IV:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Arbitration rules: lock serves dm only; guard lifts if; else iv > dm > if.
  function automatic int predictGrant();
    if (!rst) return G_NONE;
    if (m_locked) return dm_req ? G_DM : G_NONE;
    if (GUARD && if_req && m_starve >= SMAX) return G_IF;
    if (iv_req) return G_IV;
    if (dm_req) return G_DM;
    if (if_req) return G_IF;
    return G_NONE;
  endfunction

  task automatic modelUpdate(input int g);
    case (g)
      G_IF: begin
        exp_q.push_back('{G_IF, ref_mem[if_addr], cyc});
        m_starve = 0;
      end
      G_DM: begin
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        else exp_q.push_back('{G_DM, ref_mem[dm_addr], cyc});
        m_locked = dm_lock;
      end
      G_IV: exp_q.push_back('{G_IV, ref_mem[1], cyc});
      default: ;
    endcase
    if ((g == G_DM || g == G_IV) && if_req) m_starve = (m_starve >= 7) ? 7 : m_starve + 1;
    if (g != G_DM && m_locked && !dm_req && !dm_lock) m_locked = 1'b0;
  endtask

  // Drive one cycle of requests, check grant-cycle outputs, advance the model.
  task automatic applyStimulus(input bit ifr, input logic [7:0] ifa, input bit dmr, input bit we,
                               input bit lk, input logic [7:0] dma, input logic [7:0] wd,
                               input bit ivr, output int g);
    if_req = ifr; if_addr = ifa;
    dm_req = dmr; dm_we = we; dm_lock = lk; dm_addr = dma; dm_wdata = wd;
    iv_req = ivr;
    @(negedge clk);
    g = predictGrant();
    checkOutput("grants", {iv_gnt, dm_gnt, if_gnt}, ownerBits(g));
    checkOutput("stalls", {dm_stall, if_stall}, {dmr && g != G_DM, ifr && g != G_IF});
    checkOutput("mem_strobes", {mem_we, mem_re},
                {g == G_DM && we, g == G_IF || g == G_IV || (g == G_DM && !we)});
    if (g == G_IF) checkOutput("mem_addr_if", mem_addr, ifa);
    if (g == G_IV) checkOutput("mem_addr_iv", mem_addr, 8'h01);
    if (g == G_DM) begin
      checkOutput("mem_addr_dm", mem_addr, dma);
      if (we) checkOutput("mem_wdata", mem_wdata, wd);
    end
    modelUpdate(g);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    int g;
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_lock = 1'b0; iv_req = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    exp_q.delete();
    m_locked = 1'b0;
    m_starve = 0;
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  {if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall, iv_gnt, iv_rvalid,
                   mem_we, mem_re, mem_addr, mem_wdata, rdata}, 64'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Read-return monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    logic [2:0] rv;
    exp_t       e;
    rv = {iv_rvalid, dm_rvalid, if_rvalid};
    if (rv != 3'b000) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rvalid", rv, 3'b000);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rvalid_owner", rv, ownerBits(e.who));
        checkOutput("rdata", rdata, e.data);
        checkOutput("rvalid_latency", cyc, e.stamp + 1);
      end
    end else if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
      e = exp_q.pop_front();
      checkOutput("missing_rvalid", rv, ownerBits(e.who));
    end
  end

  initial begin
    int  g;
    bit  p_if, p_dm, p_iv, p_we, p_lk;
    logic [7:0] p_ifa, p_dma, p_wd;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    mem[8'h01] = 8'h7E; ref_mem[8'h01] = 8'h7E;

    doReset(2);

    // Reset in the middle of an outstanding fetch drops the read.
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
    doReset(2);

    // Lone fetch.
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
    idleCycles(2);

    // Data read beats a simultaneous fetch; fetch follows next cycle.
    applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, g);
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
    idleCycles(2);

    // Locked write, then unlocked read with iv waiting; iv follows the unlock.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h55, 1'b0, g);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, g);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, g);
    idleCycles(2);

    // Continuous dm reads with a waiting fetch (guard decides whether if gets in).
    doReset(1);
    repeat (6) applyStimulus(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h50, 8'h00, 1'b0, g);
    idleCycles(2);

    // Write followed by read-back of the same address.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 8'h3C, 1'b0, g);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, g);
    idleCycles(2);

    // Same-address write vs fetch: fetch retries and sees the new contents.
    applyStimulus(1'b1, 8'h60, 1'b1, 1'b1, 1'b0, 8'h60, 8'h99, 1'b0, g);
    applyStimulus(1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
    idleCycles(2);

    // Random traffic with held requests, occasional drops and one mid-run reset.
    p_if = 0; p_dm = 0; p_iv = 0; p_we = 0; p_lk = 0;
    p_ifa = '0; p_dma = '0; p_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        doReset(1);
        p_if = 0; p_dm = 0; p_iv = 0; p_lk = 0;
      end
      if (!p_if && $urandom_range(0, 99) < 40) begin
        p_if = 1; p_ifa = 8'($urandom);
      end else if (p_if && $urandom_range(0, 99) < 5) begin
        p_if = 0;
      end
      if (!p_dm && $urandom_range(0, 99) < 40) begin
        p_dm = 1; p_we = 1'($urandom); p_lk = ($urandom_range(0, 99) < 30);
        p_dma = 8'($urandom); p_wd = 8'($urandom);
      end else if (p_dm && $urandom_range(0, 99) < 5) begin
        p_dm = 0;
      end
      if (!p_dm) p_lk = ($urandom_range(0, 99) < 10);
      if (!p_iv && $urandom_range(0, 99) < 10) p_iv = 1;
      applyStimulus(p_if, p_ifa, p_dm, p_we, p_lk, p_dma, p_wd, p_iv, g);
      if (g == G_IF) p_if = 0;
      if (g == G_DM) p_dm = 0;
      if (g == G_IV) p_iv = 0;
    end
    idleCycles(3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
